// File: rtl/tdc_rx_readout.sv
// TDC receive readout: pops a first-word-fall-through upstream FIFO, filters words on their
// identifier nibble and buffers them for a valid/ready sink. Macro TDC_RX_READOUT_WORD_COUNT_EN adds WORD_COUNT.
module tdc_rx_readout #(
  parameter int         DEPTH           = 4,
  parameter logic [3:0] DATA_IDENTIFIER = 4'd0
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        ENABLE,
  input  logic        IN_FIFO_EMPTY,
  input  logic [31:0] IN_FIFO_DATA,
  output logic        IN_FIFO_READ,
  output logic [31:0] OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        BUSY,
  output logic [15:0] DROP_COUNT,
  output logic [31:0] WORD_COUNT
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = DEPTH[AW:0];

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]    r_state;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [31:0]   r_mem [DEPTH];
  logic [15:0]   r_drop;

  logic w_nonempty;
  logic w_read;
  logic w_match;
  logic w_push;
  logic w_pop;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Outputs are forced quiet while reset is held so a mid-stream reset never pops upstream.
  assign w_nonempty   = (r_count != '0);
  assign w_read       = !BUS_RST && (r_state == S_STREAM) && !IN_FIFO_EMPTY && (r_count < L_FULL);
  assign w_match      = (IN_FIFO_DATA[31:28] == DATA_IDENTIFIER);
  assign w_push       = w_read && w_match;
  assign w_pop        = OUT_VALID && OUT_READY;

  assign IN_FIFO_READ = w_read;
  assign OUT_VALID    = !BUS_RST && w_nonempty;
  assign OUT_DATA     = OUT_VALID ? r_mem[r_rptr] : '0;
  assign BUSY         = !BUS_RST && ((r_state != S_IDLE) || w_nonempty);
  assign DROP_COUNT   = r_drop;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (ENABLE) r_state <= S_STREAM;
        S_STREAM: if (!ENABLE) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (ENABLE)           r_state <= S_STREAM;
          else if (!w_nonempty) r_state <= S_IDLE;
        end
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_read && !w_match) r_drop <= sat_inc16(r_drop);
    end
  end

  // Buffer storage carries data only and is left out of reset.
  always_ff @(posedge BUS_CLK) begin
    if (w_push) r_mem[r_wptr] <= IN_FIFO_DATA;
  end

`ifdef TDC_RX_READOUT_WORD_COUNT_EN
  logic [31:0] r_word_cnt;

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST)    r_word_cnt <= '0;
    else if (w_pop) r_word_cnt <= r_word_cnt + 32'd1;
  end

  assign WORD_COUNT = r_word_cnt;
`else
  assign WORD_COUNT = '0;
`endif

endmodule

// File: tb/tb_tdc_rx_readout.sv
// Bench for tdc_rx_readout: queue-based reference model checked every cycle plus directed literal checks.
module tb_tdc_rx_readout;

  localparam int DEPTH    = 4;
  localparam int M_IDLE   = 0;
  localparam int M_STREAM = 1;
  localparam int M_DRAIN  = 2;
`ifdef TDC_RX_READOUT_WORD_COUNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic        empty = 1'b1;
  logic [31:0] din = '0;
  logic        rd, vld, busy;
  logic [31:0] dout, wc;
  logic [15:0] drop;

  logic        en1 = 1'b0;
  logic        ready1 = 1'b1;
  logic        empty1 = 1'b1;
  logic [31:0] din1 = '0;
  logic        rd1, vld1, busy1;
  logic [31:0] dout1, wc1;
  logic [15:0] drop1;

  logic [31:0] src[$], src1[$], msrc[$], mbuf[$], outq[$], outq1[$];
  int          mstate = M_IDLE;
  logic [15:0] mdrop = '0;
  logic [31:0] mwc = '0;
  int          n_chk = 0, n_fail = 0, pops = 0, cyc_n = 0, first_pop = -1, first_vld = -1;
  bit          chk_en = 1'b0;

  tdc_rx_readout #(.DEPTH(DEPTH), .DATA_IDENTIFIER(4'd0)) u_dut (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(en), .IN_FIFO_EMPTY(empty), .IN_FIFO_DATA(din),
    .IN_FIFO_READ(rd), .OUT_DATA(dout), .OUT_VALID(vld), .OUT_READY(ready), .BUSY(busy),
    .DROP_COUNT(drop), .WORD_COUNT(wc));

  tdc_rx_readout #(.DEPTH(DEPTH), .DATA_IDENTIFIER(4'd1)) u_dut_id1 (
    .BUS_CLK(clk), .BUS_RST(rst), .ENABLE(en1), .IN_FIFO_EMPTY(empty1), .IN_FIFO_DATA(din1),
    .IN_FIFO_READ(rd1), .OUT_DATA(dout1), .OUT_VALID(vld1), .OUT_READY(ready1), .BUSY(busy1),
    .DROP_COUNT(drop1), .WORD_COUNT(wc1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the reference model
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("IN_FIFO_READ", rd, !rst && mstate == M_STREAM && msrc.size() > 0 && mbuf.size() < DEPTH);
      chk1("OUT_VALID", vld, !rst && mbuf.size() != 0);
      if (!rst && mbuf.size() != 0) chk("OUT_DATA", dout, mbuf[0]);
      chk1("BUSY", busy, !rst && (mstate != M_IDLE || mbuf.size() != 0));
      chk("DROP_COUNT", {16'h0, drop}, {16'h0, mdrop});
      chk("WORD_COUNT", wc, WC_EN ? mwc : 32'h0);
    end
  end

  task automatic drive_src();
    empty  = (src.size() == 0);
    din    = empty ? 32'h0 : src[0];
    empty1 = (src1.size() == 0);
    din1   = empty1 ? 32'h0 : src1[0];
  endtask

  task automatic add(input logic [31:0] w);
    src.push_back(w);
    msrc.push_back(w);
    drive_src();
  endtask

  task automatic model_step();
    logic [31:0] w;
    int          occ;
    bit          take;
    if (rst) begin
      mstate = M_IDLE;
      mbuf.delete();
      mdrop = '0;
      mwc   = '0;
    end else begin
      occ  = mbuf.size();
      take = (mstate == M_STREAM) && (msrc.size() > 0) && (occ < DEPTH);
      if (occ > 0 && ready) begin
        void'(mbuf.pop_front());
        mwc = mwc + 32'd1;
      end
      if (take) begin
        w = msrc.pop_front();
        if (w[31:28] == 4'h0) mbuf.push_back(w);
        else if (mdrop != 16'hFFFF) mdrop = mdrop + 16'd1;
      end
      case (mstate)
        M_IDLE:   if (en) mstate = M_STREAM;
        M_STREAM: if (!en) mstate = M_DRAIN;
        default: begin
          if (en)            mstate = M_STREAM;
          else if (occ == 0) mstate = M_IDLE;
        end
      endcase
    end
  endtask

  task automatic cyc();
    logic        c_rd, c_vld, c_acc, c_rd1, c_acc1;
    logic [31:0] c_d, c_d1;
    @(negedge clk);
    c_rd   = rd;
    c_vld  = vld;
    c_acc  = vld && ready;
    c_d    = dout;
    c_rd1  = rd1;
    c_acc1 = vld1 && ready1;
    c_d1   = dout1;
    @(posedge clk);
    #1;
    cyc_n++;
    if (c_rd === 1'b1 && src.size() > 0) begin
      void'(src.pop_front());
      pops++;
      if (first_pop < 0) first_pop = cyc_n;
    end
    if (c_vld === 1'b1 && first_vld < 0) first_vld = cyc_n;
    if (c_rd1 === 1'b1 && src1.size() > 0) void'(src1.pop_front());
    if (c_acc === 1'b1) outq.push_back(c_d);
    if (c_acc1 === 1'b1) outq1.push_back(c_d1);
    model_step();
    drive_src();
    #1;
  endtask

  initial begin
    drive_src();
    cyc();
    cyc();
    chk_en = 1'b1;
    cyc();

    // Idle after reset: words waiting upstream but nothing happens until ENABLE
    rst = 1'b0;
    add(32'h0000_0001);
    for (int i = 2; i <= 8; i++) add(32'(i));
    cyc();
    cyc();
    chk1("idle_read", rd, 1'b0);
    chk1("idle_valid", vld, 1'b0);
    chk1("idle_busy", busy, 1'b0);
    chk("idle_data", dout, 32'h0);

    // Streaming eight words with the sink always ready
    ready = 1'b1;
    en = 1'b1;
    first_pop = -1;
    first_vld = -1;
    repeat (16) cyc();
    chk("stream_latency", 32'(first_vld - first_pop), 32'd1);
    chk("stream_count", 32'(outq.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("stream_word", outq[i], 32'(i + 1));
    chk("stream_drop", {16'h0, drop}, 32'h0);

    // Backpressure: buffer fills to DEPTH and holds its head
    outq.delete();
    ready = 1'b0;
    pops = 0;
    for (int i = 1; i <= 6; i++) add(32'h0000_0A00 + 32'(i));
    repeat (8) cyc();
    chk("full_pops", 32'(pops), 32'd4);
    chk1("full_read", rd, 1'b0);
    chk("full_head", dout, 32'h0000_0A01);
    repeat (2) cyc();
    chk("full_head_held", dout, 32'h0000_0A01);
    ready = 1'b1;
    repeat (14) cyc();
    chk("full_count", 32'(outq.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("full_word", outq[i], 32'h0000_0A01 + 32'(i));

    // Identifier filtering on both instances
    outq.delete();
    outq1.delete();
    add(32'h0000_0005);
    add(32'h2000_0006);
    add(32'h0000_0007);
    src1.push_back(32'h1000_0005);
    src1.push_back(32'h2000_0006);
    src1.push_back(32'h1000_0007);
    drive_src();
    en1 = 1'b1;
    repeat (10) cyc();
    chk("id0_count", 32'(outq.size()), 32'd2);
    chk("id0_word0", outq[0], 32'h0000_0005);
    chk("id0_word1", outq[1], 32'h0000_0007);
    chk("id0_drop", {16'h0, drop}, 32'd1);
    chk("id1_count", 32'(outq1.size()), 32'd2);
    chk("id1_word0", outq1[0], 32'h1000_0005);
    chk("id1_word1", outq1[1], 32'h1000_0007);
    chk("id1_drop", {16'h0, drop1}, 32'd1);
    en1 = 1'b0;

    // Drain: three buffered words, ENABLE dropped, no further pops
    outq.delete();
    ready = 1'b0;
    for (int i = 1; i <= 3; i++) add(32'h0000_0B00 + 32'(i));
    repeat (5) cyc();
    en = 1'b0;
    cyc();
    pops = 0;
    add(32'h0000_0C01);
    add(32'h0000_0C02);
    repeat (3) cyc();
    chk("drain_no_pop", 32'(pops), 32'd0);
    chk1("drain_busy", busy, 1'b1);
    ready = 1'b1;
    repeat (5) cyc();
    chk("drain_pops", 32'(pops), 32'd0);
    chk("drain_count", 32'(outq.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("drain_word", outq[i], 32'h0000_0B01 + 32'(i));
    chk1("drain_idle_busy", busy, 1'b0);
    src.delete();
    msrc.delete();
    drive_src();

    // Reset with two words buffered
    ready = 1'b0;
    en = 1'b1;
    add(32'h0000_0D01);
    add(32'h0000_0D02);
    repeat (4) cyc();
    chk1("prerst_valid", vld, 1'b1);
    rst = 1'b1;
    #1;
    chk1("inrst_read", rd, 1'b0);
    chk1("inrst_valid", vld, 1'b0);
    cyc();
    rst = 1'b0;
    en = 1'b0;
    #1;
    chk1("rst_valid", vld, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_drop", {16'h0, drop}, 32'h0);
    chk("rst_wc", wc, 32'h0);
    chk("rst_data", dout, 32'h0);

    // Ten deliveries for WORD_COUNT
    outq.delete();
    ready = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 10; i++) add(32'h0000_0E00 + 32'(i));
    repeat (16) cyc();
    chk("wc_count", 32'(outq.size()), 32'd10);
    chk("wc_value", wc, WC_EN ? 32'd10 : 32'd0);
    en = 1'b0;
    repeat (3) cyc();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
